core_sequencer: RTL and testbench

Instruction sequencer that sits directly upstream of the corelet and its activation/weight SRAM (xmem) and partial-sum SRAM (pmem). On `start` it steps through every kernel position (kij) in order: load weights, push the kernel, stream activations, execute, drain, then write partial sums back. Each step drives the 35-bit instruction word the corelet and SRAMs consume. An optional final phase drives SFP accumulation across kij.

---
 rtl/core_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_core_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: per-kij instruction sequencer for corelet, xmem and pmem; optional SFP phase under CORE_SEQUENCER_ACC_EN.
// Latency: first instruction one cycle after start is sampled; all outputs registered, no input-to-inst path.
// Backpressure: l0_full stalls xmem reads in KLOAD/ALOAD, ofifo_valid low stalls OREAD; in-flight writes always complete.
module core_sequencer #(
    parameter int          row     = 8,
    parameter int          col     = 8,
    parameter int          len_kij = 9,
    parameter int          len_nij = 36,
    parameter logic [10:0] W_BASE  = 11'd64,
    parameter logic [10:0] A_BASE  = 11'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic        l0_full,
    input  logic        ofifo_valid,
    output logic [34:0] inst,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_KLOAD = 4'd1;
    localparam logic [3:0] S_KPUSH = 4'd2;
    localparam logic [3:0] S_ALOAD = 4'd3;
    localparam logic [3:0] S_EXEC  = 4'd4;
    localparam logic [3:0] S_DRAIN = 4'd5;
    localparam logic [3:0] S_OREAD = 4'd6;
`ifdef CORE_SEQUENCER_ACC_EN
    localparam logic [3:0] S_ACC   = 4'd7;
`endif
    localparam logic [3:0] S_FIN   = 4'd8;

    localparam logic [34:0] INST_IDLE = 35'h1_800C_0000;

    localparam logic [10:0] COL_C    = 11'(col);
    localparam logic [10:0] NIJ_C    = 11'(len_nij);
    localparam logic [10:0] RC_C     = 11'(row + col);
    localparam logic [10:0] KIJ_LAST = 11'(len_kij - 1);
`ifdef CORE_SEQUENCER_ACC_EN
    localparam logic [10:0] KIJ_C    = 11'(len_kij);
    localparam logic [10:0] NIJ_LAST = 11'(len_nij - 1);
    localparam logic [10:0] ACC_LAST = 11'(len_kij + 2);
`endif

    logic [3:0]  state, state_nx;
    logic [10:0] i, i_nx, kij, kij_nx, n, n_nx, idx, ld_len;
    logic        mode_q, mode_nx, busy_nx, done_nx, fresh;
    logic [34:0] inst_nx;
    logic        cur_xrd, cur_ord;

    // Write strobes follow the read issued in the current cycle, so the registered inst is the pipeline tag.
    assign cur_xrd = ~inst[18];
    assign cur_ord = inst[6];

    always_comb begin
        state_nx = state;
        kij_nx   = kij;
        n_nx     = n;
        mode_nx  = mode_q;
        busy_nx  = busy;
        done_nx  = 1'b0;
        inst_nx  = INST_IDLE;
        fresh    = 1'b0;
        idx      = i;
        i_nx     = i;
        ld_len   = NIJ_C;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_KLOAD;
                    mode_nx  = mode;
                    busy_nx  = 1'b1;
                    kij_nx   = '0;
                    n_nx     = '0;
                end
            end
            S_KLOAD: if (i == COL_C && !cur_xrd) state_nx = mode_q ? S_ALOAD : S_KPUSH;
            S_KPUSH: if (i == COL_C) state_nx = S_ALOAD;
            S_ALOAD: if (i == NIJ_C && !cur_xrd) state_nx = S_EXEC;
            S_EXEC:  if (i == NIJ_C) state_nx = S_DRAIN;
            S_DRAIN: if (i == RC_C) state_nx = S_OREAD;
            S_OREAD: begin
                if (i == NIJ_C && !cur_ord) begin
                    if (kij == KIJ_LAST) begin
`ifdef CORE_SEQUENCER_ACC_EN
                        state_nx = S_ACC;
`else
                        state_nx = S_FIN;
`endif
                    end else begin
                        kij_nx   = kij + 11'd1;
                        state_nx = S_KLOAD;
                    end
                end
            end
`ifdef CORE_SEQUENCER_ACC_EN
            S_ACC: begin
                if (i == ACC_LAST) begin
                    if (n == NIJ_LAST) begin
                        state_nx = S_FIN;
                    end else begin
                        n_nx  = n + 11'd1;
                        fresh = 1'b1;
                    end
                end
            end
`endif
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        if (state_nx != state) fresh = 1'b1;
        if (fresh) idx = '0;

        inst_nx[34] = (state_nx == S_IDLE) ? 1'b0 : mode_nx;

        case (state_nx)
            S_KLOAD, S_ALOAD: begin
                ld_len = (state_nx == S_KLOAD) ? COL_C : NIJ_C;
                if (!fresh && cur_xrd) begin
                    if (state_nx == S_KLOAD && mode_q) inst_nx[4] = 1'b1;
                    else                               inst_nx[2] = 1'b1;
                end
                if (idx < ld_len && !l0_full) begin
                    inst_nx[18]   = 1'b0;
                    inst_nx[17:7] = (state_nx == S_KLOAD) ? (W_BASE + kij_nx * COL_C + idx)
                                                          : (A_BASE + idx);
                    i_nx = idx + 11'd1;
                end else begin
                    i_nx = idx;
                end
            end
            S_KPUSH: begin
                inst_nx[3] = 1'b1;
                inst_nx[0] = 1'b1;
                i_nx       = idx + 11'd1;
            end
            S_EXEC: begin
                inst_nx[3] = 1'b1;
                inst_nx[1] = 1'b1;
                inst_nx[5] = mode_q;
                i_nx       = idx + 11'd1;
            end
            S_DRAIN: i_nx = idx + 11'd1;
            S_OREAD: begin
                if (!fresh && cur_ord) begin
                    inst_nx[31]    = 1'b0;
                    inst_nx[32]    = 1'b0;
                    inst_nx[30:20] = kij * NIJ_C + i - 11'd1;
                end
                if (idx < NIJ_C && ofifo_valid) begin
                    inst_nx[6] = 1'b1;
                    i_nx       = idx + 11'd1;
                end else begin
                    i_nx = idx;
                end
            end
`ifdef CORE_SEQUENCER_ACC_EN
            // Pass position idx: reads at 0..len_kij-1, accumulate one cycle behind, then write the sum.
            S_ACC: begin
                if (idx < KIJ_C) begin
                    inst_nx[31]    = 1'b0;
                    inst_nx[30:20] = idx * NIJ_C + n_nx;
                end
                if (idx != 11'd0 && idx <= KIJ_C) inst_nx[33] = 1'b1;
                if (idx == KIJ_C + 11'd1) begin
                    inst_nx[31]    = 1'b0;
                    inst_nx[32]    = 1'b0;
                    inst_nx[30:20] = KIJ_C * NIJ_C + n_nx;
                end
                i_nx = idx + 11'd1;
            end
`endif
            S_FIN: begin
                busy_nx = 1'b0;
                done_nx = 1'b1;
                i_nx    = '0;
            end
            default: begin
                busy_nx = 1'b0;
                i_nx    = '0;
                kij_nx  = '0;
                n_nx    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            i      <= '0;
            kij    <= '0;
            n      <= '0;
            mode_q <= 1'b0;
            inst   <= INST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            i      <= i_nx;
            kij    <= kij_nx;
            n      <= n_nx;
            mode_q <= mode_nx;
            inst   <= inst_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: table of whole-run scenarios plus hand-written reset and idle sequences.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        l0_full = 1'b0;
    logic        ofifo_valid = 1'b1;
    logic [34:0] inst;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    localparam logic [34:0] INST_IDLE = 35'h1_800C_0000;
`ifdef CORE_SEQUENCER_ACC_EN
    localparam int ACC_CYC = 396;
    localparam int ACC_WR  = 36;
    localparam int ACC_PUL = 324;
`else
    localparam int ACC_CYC = 0;
    localparam int ACC_WR  = 0;
    localparam int ACC_PUL = 0;
`endif

    typedef struct {
        logic mode;
        logic stall;
        logic toggle;
        int   exp_cyc;
        int   exp_kpush;
        int   exp_ififo_wr;
        int   exp_l0_wr;
        int   exp_ififo_rd;
        int   exp_idle;
    } vec_t;

    core_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .l0_full     (l0_full),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int cyc = 0;
        int done_cyc = -1;
        int k_cnt = 0, fw_cnt = 0, l0w_cnt = 0, frd_cnt = 0, idle_win = 0;
        int w_cnt = 0, w_viol = 0, a_cnt = 0, a_viol = 0, xw_viol = 0;
        int of_cnt = 0, of_viol = 0, pw_cnt = 0, pw_viol = 0, pr_cnt = 0, pr_viol = 0;
        int acc_cnt = 0, acc_since = 0, acc_viol = 0, mode_viol = 0, busy_viol = 0;
        logic        prev_valid;
        logic [10:0] exp_w = 11'd64;
        logic [10:0] first_x = 11'h7FF;
        logic [10:0] last_w = 11'd0;
        logic [10:0] addr;

        @(negedge clk);
        start       = 1'b1;
        mode        = v.mode;
        l0_full     = 1'b0;
        ofifo_valid = v.toggle ? 1'b0 : 1'b1;
        prev_valid  = ofifo_valid;
        while (done_cyc < 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            addr = inst[17:7];
            if (cyc == 1) first_x = inst[18] ? 11'h7FF : addr;
            if (!inst[18]) begin
                if (!inst[19]) xw_viol++;
                if (addr >= 11'd64) begin
                    if (addr != exp_w) w_viol++;
                    exp_w  = exp_w + 11'd1;
                    last_w = addr;
                    w_cnt++;
                end else begin
                    if (int'(addr) != a_cnt % 36) a_viol++;
                    a_cnt++;
                end
            end
            if (cyc >= 31 && cyc <= 34 && inst[18]) idle_win++;
            if (inst[0]) k_cnt++;
            if (inst[2]) l0w_cnt++;
            if (inst[4]) fw_cnt++;
            if (inst[5]) frd_cnt++;
            if (inst[6]) begin
                of_cnt++;
                if (!prev_valid) of_viol++;
            end
            if (inst[33]) begin
                acc_cnt++;
                acc_since++;
            end
            if (!inst[31] && !inst[32]) begin
                if (int'(inst[30:20]) != pw_cnt) pw_viol++;
                if (acc_since != ((pw_cnt >= 324) ? 9 : 0)) acc_viol++;
                acc_since = 0;
                pw_cnt++;
            end
            if (!inst[31] && inst[32]) begin
                if (int'(inst[30:20]) != (pr_cnt % 9) * 36 + pr_cnt / 9) pr_viol++;
                pr_cnt++;
            end
            if (inst[34] != v.mode) mode_viol++;
            if (done ? busy : !busy) busy_viol++;
            if (done) done_cyc = cyc;

            start       = (cyc == 200);
            mode        = ~v.mode;
            l0_full     = v.stall && cyc >= 30 && cyc <= 33;
            ofifo_valid = v.toggle ? cyc[0] : 1'b1;
            prev_valid  = ofifo_valid;
        end
        start       = 1'b0;
        l0_full     = 1'b0;
        ofifo_valid = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d idle inst after run", id), inst, INST_IDLE);
        check($sformatf("v%0d idle busy after run", id), busy, 0);
        check($sformatf("v%0d done cycle", id), done_cyc, v.exp_cyc);
        check($sformatf("v%0d kernel pushes", id), k_cnt, v.exp_kpush);
        check($sformatf("v%0d ififo_wr pulses", id), fw_cnt, v.exp_ififo_wr);
        check($sformatf("v%0d l0_wr pulses", id), l0w_cnt, v.exp_l0_wr);
        check($sformatf("v%0d ififo_rd pulses", id), frd_cnt, v.exp_ififo_rd);
        check($sformatf("v%0d stall idle cycles", id), idle_win, v.exp_idle);
        check($sformatf("v%0d first xmem addr", id), first_x, 64);
        check($sformatf("v%0d last weight addr", id), last_w, 135);
        check($sformatf("v%0d weight reads", id), w_cnt, 72);
        check($sformatf("v%0d weight addr order", id), w_viol, 0);
        check($sformatf("v%0d act reads", id), a_cnt, 324);
        check($sformatf("v%0d act addr order", id), a_viol, 0);
        check($sformatf("v%0d xmem writes", id), xw_viol, 0);
        check($sformatf("v%0d ofifo reads", id), of_cnt, 324);
        check($sformatf("v%0d ofifo read w/o valid", id), of_viol, 0);
        check($sformatf("v%0d pmem writes", id), pw_cnt, 324 + ACC_WR);
        check($sformatf("v%0d pmem write addr order", id), pw_viol, 0);
        check($sformatf("v%0d pmem reads", id), pr_cnt, ACC_PUL);
        check($sformatf("v%0d pmem read addr order", id), pr_viol, 0);
        check($sformatf("v%0d sfp acc pulses", id), acc_cnt, ACC_PUL);
        check($sformatf("v%0d acc pulses per write", id), acc_viol, 0);
        check($sformatf("v%0d mode bit", id), mode_viol, 0);
        check($sformatf("v%0d busy/done", id), busy_viol, 0);
    endtask

    initial begin
        vec_t vecs[4];
        vecs[0] = '{mode: 1'b0, stall: 1'b0, toggle: 1'b0, exp_cyc: 1288 + ACC_CYC,
                    exp_kpush: 72, exp_ififo_wr: 0, exp_l0_wr: 396, exp_ififo_rd: 0, exp_idle: 0};
        vecs[1] = '{mode: 1'b1, stall: 1'b0, toggle: 1'b0, exp_cyc: 1216 + ACC_CYC,
                    exp_kpush: 0, exp_ififo_wr: 72, exp_l0_wr: 324, exp_ififo_rd: 324, exp_idle: 0};
        vecs[2] = '{mode: 1'b0, stall: 1'b1, toggle: 1'b0, exp_cyc: 1292 + ACC_CYC,
                    exp_kpush: 72, exp_ififo_wr: 0, exp_l0_wr: 396, exp_ififo_rd: 0, exp_idle: 4};
        vecs[3] = '{mode: 1'b0, stall: 1'b0, toggle: 1'b1, exp_cyc: 1604 + ACC_CYC,
                    exp_kpush: 72, exp_ififo_wr: 0, exp_l0_wr: 396, exp_ififo_rd: 0, exp_idle: 0};

        #1 reset = 1'b1;
        #1;
        check("reset inst", inst, INST_IDLE);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the fifth KLOAD cycle must drop straight back to idle outputs.
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("kload read before reset", inst[18], 0);
        check("kload addr before reset", inst[17:7], 68);
        reset = 1'b1;
        #1;
        check("mid-run reset inst", inst, INST_IDLE);
        check("mid-run reset busy", busy, 0);
        check("mid-run reset done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle inst after reset release", inst, INST_IDLE);

        for (int k = 0; k < 4; k++) run_vec(k, vecs[k]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
